seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL expose port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL expose port in_valid  input  1  operands valid.
REQ-005 The block SHALL expose port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL expose port inA  input  WIDTH  multiplicand.
REQ-007 The block SHALL expose port inB  input  WIDTH  multiplier.
REQ-008 The block SHALL expose port out  output  2*WIDTH  product.
REQ-009 The block SHALL expose port out_valid  output  1  product valid.
REQ-010 The block SHALL expose port out_ready  input  1  consumer accepts product.
REQ-011 The block SHALL expose port busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 In IDLE the block SHALL drive in_ready=1; in CALC and DONE it SHALL drive in_ready=0.
REQ-014 An accept SHALL occur on the rising edge where in_valid=1 and in_ready=1; the block SHALL then latch inA and inB, clear the accumulator and iteration counter, and enter CALC.
REQ-015 Each CALC cycle SHALL perform one shift-add step: if the current multiplier bit is 1, add the multiplicand (shifted to the bit position) into the 2*WIDTH-bit accumulator; then advance the bit index.
REQ-016 Accumulator adds SHALL be performed modulo 2^(2*WIDTH); carry-out beyond bit 2*WIDTH-1 SHALL be discarded.
REQ-017 After exactly WIDTH CALC cycles the block SHALL enter DONE; out_valid SHALL first be high in the cycle following the WIDTH-th rising edge after the accept edge.
REQ-018 In DONE the block SHALL hold out_valid=1 and SHALL hold out stable until a rising edge with out_ready=1; on that edge it SHALL return to IDLE and deassert out_valid.
REQ-019 in_valid SHALL be ignored in CALC and DONE; operand changes after the accept edge SHALL NOT affect the result.
REQ-020 out_ready SHALL be ignored outside DONE.
REQ-021 out SHALL retain the last product in IDLE until the next accept edge clears the accumulator.
REQ-022 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.
REQ-023 Zero operands SHALL still take the full WIDTH CALC cycles; there is no early termination.

Reset
REQ-024 When rst=1 on a rising edge, the block SHALL enter IDLE regardless of state, including mid-CALC or DONE with a pending product, and SHALL discard any in-flight operation.
REQ-025 After reset the block SHALL drive out=0, out_valid=0, busy=0 and in_ready=1, with the counter and latched operands cleared.
REQ-026 If rst and in_valid are both high on the same edge, reset SHALL win and no accept SHALL occur.

Configuration
REQ-027 The macro SEQ_MULTIPLIER_SIGNED_EN SHALL gate signed operation.
REQ-028 When SEQ_MULTIPLIER_SIGNED_EN is defined, the block SHALL add input port is_signed (1 bit), latched on the accept edge.
REQ-029 With is_signed=1, the block SHALL treat operands as two's complement and produce the exact signed 2*WIDTH-bit product, with the same latency; with is_signed=0 it SHALL behave as when the macro is undefined.
REQ-030 When SEQ_MULTIPLIER_SIGNED_EN is undefined, the is_signed port SHALL be absent and all operations SHALL be unsigned.

Verification
REQ-031 WIDTH=8: inA=255, inB=255 accepted -> out=16'hFE01 with out_valid high 8 edges after accept; inA=0, inB=173 -> out=0 after the same latency.
REQ-032 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge with in_ready=1.
REQ-033 Reset mid-operation: assert rst at CALC cycle 3 -> next cycle out=0, out_valid=0, in_ready=1; a new accept of 3x5 -> out=15.
REQ-034 Signed, macro defined, is_signed=1, WIDTH=8: -128 x -128 -> 16'h4000; -1 x 1 -> 16'hFFFF; the same operands with is_signed=0 -> 16'h4000 and 16'h00FF.
REQ-035 WIDTH=16: 16'hFFFF x 16'hFFFF -> 32'hFFFE0001, with out_valid high 16 edges after accept.
REQ-036 Operand change: alter inA and inB during CALC -> result equals the product of the values latched at the accept edge.

Source files
------------

// File: rtl/seq_multiplier.sv
//==============================================================================
// Module      : seq_multiplier
// Description : Sequential shift-add multiplier with valid/ready handshakes.
//               Takes WIDTH CALC cycles per product and holds the result in
//               DONE until the consumer accepts it.
//               Optional macro SEQ_MULTIPLIER_SIGNED_EN adds the is_signed
//               port for two's-complement operation.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
   input  logic                 is_signed,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     inA,
   input  logic [WIDTH-1:0]     inB,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   // Counter reaches WIDTH after the last step, so it needs one extra bit
   // of headroom to avoid wrapping within an operation.
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;    // multiplicand, pre-shifted to current bit
   logic [WIDTH-1:0]     mplier;   // multiplier, LSB is the current bit
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic                 sgn;      // operation latched as signed
   logic                 sign_in;  // signed request at the accept edge
   logic [2*WIDTH-1:0]   ext_a;
   logic                 last_step;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   assign sign_in = is_signed;
`else
   assign sign_in = 1'b0;
`endif

   // Multiplicand widened to product width: sign-extended when signed, so
   // every shifted add is already correct modulo 2^(2*WIDTH).
   assign ext_a     = {{WIDTH{sign_in & inA[WIDTH-1]}}, inA};
   assign last_step = (cnt == LAST);
   assign out       = acc;

   // Control FSM and datapath: one shift-add step per CALC cycle. In signed
   // mode the multiplier MSB carries weight -2^(WIDTH-1), so that final
   // partial product is subtracted instead of added.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         sgn       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mcand    <= ext_a;
                  mplier   <= inB;
                  sgn      <= sign_in;
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               if (mplier[0]) begin
                  acc <= (sgn && last_step) ? (acc - mcand) : (acc + mcand);
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last_step) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
//==============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier (WIDTH=8 main DUT plus
//               a WIDTH=16 instance). Signed cases run when
//               SEQ_MULTIPLIER_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_multiplier;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]     a, b;
   logic [2*W-1:0]   out;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
   logic             is_signed;
`endif

   logic             v16, rdy16, ov16, ordy16, busy16;
   logic [15:0]      a16, b16;
   logic [31:0]      out16;

   int n_vec = 0;
   int n_bad = 0;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      .is_signed (is_signed),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (a),
      .inB       (b),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   seq_multiplier #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      .is_signed (1'b0),
`endif
      .in_valid  (v16),
      .in_ready  (rdy16),
      .inA       (a16),
      .inB       (b16),
      .out       (out16),
      .out_valid (ov16),
      .out_ready (ordy16),
      .busy      (busy16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference product: plain integer multiply, truncated to 2*w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic s);
      longint sx, sy, p;
      logic [63:0] mask;
      sx = longint'(x);
      sy = longint'(y);
      if (s && x[w-1]) sx = sx - (longint'(1) << w);
      if (s && y[w-1]) sy = sy - (longint'(1) << w);
      p    = sx * sy;
      mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      return 64'(p) & mask;
   endfunction

   function automatic logic eff_signed(input logic s);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      return s;
`else
      return s & 1'b0;
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input int hold);
      logic [63:0] exp;
      int lat;
      exp = ref_mul(W, 32'(xa), 32'(xb), eff_signed(xs));
      lat = 0;
      while (!in_ready && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ready_before_accept", 64'(in_ready), 64'd1);
      a = xa;
      b = xb;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      is_signed = xs;
`endif
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      // Disturb all inputs after the accept edge; none may matter now.
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      is_signed = ~xs;
`endif
      check("busy_calc", 64'(busy), 64'd1);
      check("in_ready_calc", 64'(in_ready), 64'd0);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         out_ready = 1'($urandom_range(0, 1));
      end while (!out_valid && lat < 3 * W);
      out_ready = 1'b0;
      check("latency", 64'(lat), 64'(W));
      check("product", 64'(out), exp);
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold_out", 64'(out), exp);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd1);
      check("release_busy", 64'(busy), 64'd0);
      check("retain_out", 64'(out), exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      is_signed = 1'b0;
`endif
      v16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", 64'(out), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;

      run_op(8'd255, 8'd255, 1'b0, 5);
      check("const_fe01", 64'(out), 64'hFE01);
      run_op(8'd0, 8'd173, 1'b0, 0);
      check("const_zero", 64'(out), 64'd0);

      // Reset in the middle of CALC discards the operation.
      a = 8'd9; b = 8'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out", 64'(out), 64'd0);
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);

      // Reset and in_valid on the same edge: no accept.
      rst = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd3;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_wins_busy", 64'(busy), 64'd0);
      check("rst_wins_ready", 64'(in_ready), 64'd1);

      run_op(8'd3, 8'd5, 1'b0, 1);
      check("const_15", 64'(out), 64'd15);
      run_op(8'd1, 8'd255, 1'b0, 0);
      run_op(8'd255, 8'd0, 1'b0, 2);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
      run_op(8'h80, 8'h80, 1'b1, 1);
      check("s_4000", 64'(out), 64'h4000);
      run_op(8'hFF, 8'h01, 1'b1, 0);
      check("s_ffff", 64'(out), 64'hFFFF);
      run_op(8'h80, 8'h80, 1'b0, 0);
      check("u_4000", 64'(out), 64'h4000);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      check("u_00ff", 64'(out), 64'h00FF);
`endif

      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)));
      end

      // WIDTH=16 instance.
      a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0; a16 = 16'h1234; b16 = 16'h0042;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ov16 && lat < 48);
      check("w16_latency", 64'(lat), 64'd16);
      check("w16_product", 64'(out16), 64'hFFFE0001);
      check("w16_model", 64'(out16), ref_mul(16, 32'hFFFF, 32'hFFFF, 1'b0));
      ordy16 = 1'b1;
      @(posedge clk); #1;
      ordy16 = 1'b0;
      check("w16_release", 64'(ov16), 64'd0);
      check("w16_ready", 64'(rdy16), 64'd1);
      check("w16_busy", 64'(busy16), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
